// File: rtl/hr_pkg.sv
// hr_pkg: shared state encoding and defaults for the heart-rate poll sequencer
package hr_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_REL, S_UPD} state_t;
  localparam logic [7:0] DEV_ADDR_DEF = 8'h0A;
  localparam logic [7:0] REG_ADDR_DEF = 8'h00;
  localparam int AVG_LOG2_DEF = 2;
endpackage

// File: rtl/hr_moving_avg.sv
// hr_moving_avg: ring-buffer moving average, bpm pulses only once the window is full
module hr_moving_avg import hr_pkg::*; #(
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] bpm,
  output logic       bpm_valid
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW = 8 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FULL = {1'b1, {AVG_LOG2{1'b0}}};
  logic [7:0] ring [DEPTH];
  logic [SW-1:0] sum, sum_nxt;
  logic [AVG_LOG2-1:0] ptr;
  logic [AVG_LOG2:0] fill, fill_nxt;
  assign sum_nxt = sum - SW'(ring[ptr]) + SW'(din);
  assign fill_nxt = (fill == FULL) ? FULL : fill + 1'b1;
  always_ff @(posedge clk) begin
    bpm_valid <= 1'b0;
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      sum <= '0;
      ptr <= '0;
      fill <= '0;
      if (reset) bpm <= '0;
    end else if (wr) begin
      ring[ptr] <= din;
      sum <= sum_nxt;
      ptr <= ptr + 1'b1;
      fill <= fill_nxt;
      if (fill_nxt == FULL) begin
        bpm <= 8'(sum_nxt >> AVG_LOG2);
        bpm_valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/hr_poll_sequencer.sv
// hr_poll_sequencer: periodic I2C read sequencer with timeout and averaged BPM output
module hr_poll_sequencer import hr_pkg::*; #(
  parameter int POLL_PERIOD = 50_000,
  parameter int TIMEOUT = 4_096,
  parameter logic [7:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter logic [7:0] REG_ADDR = REG_ADDR_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       i2c_send,
  output logic [7:0] i2c_add,
  output logic [7:0] i2c_regis,
  input  logic       i2c_busy,
  input  logic [7:0] i2c_dout,
  output logic [7:0] sample,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       no_contact,
  output logic       timeout_err,
  input  logic       err_clear
);
  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] P_LOAD = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  state_t state;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic send_q, to_hit, upd_wr, upd_flush;
  logic [7:0] cap;
  assign i2c_add = DEV_ADDR;
  assign i2c_regis = REG_ADDR;
  // send is gated so a reset mid-request releases the bus without waiting an edge
  assign i2c_send = send_q & ~reset;
  assign to_hit = tcnt == T_LAST && ((state == S_REQ && !i2c_busy) || (state == S_REL && i2c_busy));
  assign upd_wr = state == S_UPD && cap != 8'h00;
  assign upd_flush = state == S_UPD && cap == 8'h00;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pcnt <= '0;
      tcnt <= '0;
      send_q <= 1'b0;
      cap <= '0;
      sample <= '0;
      no_contact <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_hit | (timeout_err & ~err_clear);
      case (state)
        S_IDLE: if (enable) begin
          state <= S_WAIT;
          pcnt <= P_LOAD;
        end
        S_WAIT: if (!enable) state <= S_IDLE;
        else if (pcnt == '0) begin
          state <= S_REQ;
          send_q <= 1'b1;
          tcnt <= '0;
        end else pcnt <= pcnt - 1'b1;
        S_REQ: if (i2c_busy) begin
          cap <= i2c_dout;
          send_q <= 1'b0;
          tcnt <= '0;
          state <= S_REL;
        end else if (to_hit) begin
          send_q <= 1'b0;
          pcnt <= P_LOAD;
          state <= S_WAIT;
        end else tcnt <= tcnt + 1'b1;
        S_REL: if (!i2c_busy) state <= S_UPD;
        else if (to_hit) begin
          pcnt <= P_LOAD;
          state <= S_WAIT;
        end else tcnt <= tcnt + 1'b1;
        S_UPD: begin
          sample <= cap;
          no_contact <= cap == 8'h00;
          pcnt <= P_LOAD;
          state <= enable ? S_WAIT : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  hr_moving_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk(clk),
    .reset(reset),
    .flush(upd_flush),
    .wr(upd_wr),
    .din(cap),
    .bpm(bpm),
    .bpm_valid(bpm_valid)
  );
endmodule

// File: tb/tb_hr_poll_sequencer.sv
// tb_hr_poll_sequencer: randomized I2C responder checked against a timestamp/queue reference model
module tb_hr_poll_sequencer;
  localparam int P = 10;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset, enable, i2c_busy, err_clear;
  logic [7:0] i2c_dout;
  logic i2c_send, bpm_valid, no_contact, timeout_err;
  logic [7:0] i2c_add, i2c_regis, sample, bpm;
  int total = 0, bad = 0, cyc = 0, vcnt = 0;
  always #5 clk = ~clk;
  hr_poll_sequencer #(.POLL_PERIOD(P), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .i2c_send(i2c_send), .i2c_add(i2c_add),
    .i2c_regis(i2c_regis), .i2c_busy(i2c_busy), .i2c_dout(i2c_dout), .sample(sample),
    .bpm(bpm), .bpm_valid(bpm_valid), .no_contact(no_contact), .timeout_err(timeout_err),
    .err_clear(err_clear)
  );
  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // reference model: phase 0 off, 1 counting down to send_at, 2 requesting, 3 releasing, 4 updating
  int phase = 0;
  longint now = 0, send_at = 0, t0 = 0;
  bit m_err = 0, m_nc = 0, m_valid = 0, to_ev = 0;
  int m_sample = 0, m_bpm = 0, m_cap = 0, hsum = 0;
  int hist[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    now++;
    m_valid = 0;
    to_ev = 0;
    if (reset) begin
      phase = 0;
      hist.delete();
      m_sample = 0; m_bpm = 0; m_nc = 0; m_err = 0;
    end else begin
      if (phase == 0) begin
        if (enable) begin phase = 1; send_at = now + P; end
      end else if (phase == 1) begin
        if (!enable) phase = 0;
        else if (now == send_at) begin phase = 2; t0 = now; end
      end else if (phase == 2) begin
        if (i2c_busy) begin m_cap = i2c_dout; phase = 3; t0 = now; end
        else if (now - t0 == TO) begin to_ev = 1; phase = 1; send_at = now + P; end
      end else if (phase == 3) begin
        if (!i2c_busy) phase = 4;
        else if (now - t0 == TO) begin to_ev = 1; phase = 1; send_at = now + P; end
      end else begin
        m_sample = m_cap;
        if (m_cap == 0) begin
          m_nc = 1;
          hist.delete();
        end else begin
          m_nc = 0;
          hist.push_back(m_cap);
          if (hist.size() > 4) void'(hist.pop_front());
          if (hist.size() == 4) begin
            hsum = 0;
            foreach (hist[i]) hsum += hist[i];
            m_bpm = hsum / 4;
            m_valid = 1;
          end
        end
        phase = enable ? 1 : 0;
        send_at = now + P;
      end
      m_err = to_ev | (m_err & !err_clear);
    end
  end
  always @(posedge clk) begin
    #1;
    if (bpm_valid) vcnt++;
    cmp("send", int'(i2c_send), int'(phase == 2 && !reset));
    cmp("sample", int'(sample), m_sample);
    cmp("bpm", int'(bpm), m_bpm);
    cmp("bpm_valid", int'(bpm_valid), int'(m_valid));
    cmp("no_contact", int'(no_contact), int'(m_nc));
    cmp("timeout_err", int'(timeout_err), int'(m_err));
    cmp("add", int'(i2c_add), 8'h0A);
    cmp("regis", int'(i2c_regis), 8'h00);
  end
  task automatic poll(input logic [7:0] v);
    int n = 0;
    while (!i2c_send && n < 100) begin @(negedge clk); n++; end
    cmp("send_rise", int'(i2c_send), 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    i2c_busy = 1'b1;
    i2c_dout = v;
    n = 0;
    while (i2c_send && n < 40) begin @(negedge clk); n++; end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    i2c_busy = 1'b0;
    i2c_dout = 8'($urandom);
    repeat (2) @(negedge clk);
  endtask
  task automatic send_latency(input string nm, input int c0);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!i2c_send && n < 100);
    cmp(nm, cyc - c0, P + 1);
    @(negedge clk);
  endtask
  initial begin
    int c0, n, v0, r;
    reset = 1'b1; enable = 1'b0; i2c_busy = 1'b0; i2c_dout = '0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cmp("rst_send", int'(i2c_send), 0);
    cmp("rst_bpm", int'(bpm), 0);
    cmp("rst_sample", int'(sample), 0);
    cmp("rst_err", int'(timeout_err), 0);
    cmp("rst_nc", int'(no_contact), 0);
    c0 = cyc;
    enable = 1'b1;
    send_latency("first_send_lat", c0);
    v0 = vcnt;
    poll(8'd72); poll(8'd74); poll(8'd76); poll(8'd78);
    cmp("four_valid_cnt", vcnt - v0, 1);
    cmp("bpm_75", int'(bpm), 75);
    poll(8'd90);
    cmp("bpm_wrap_79", int'(bpm), 79);
    poll(8'd0);
    cmp("nc_set", int'(no_contact), 1);
    v0 = vcnt;
    poll(8'd10); poll(8'd20); poll(8'd30);
    cmp("flush_no_valid", vcnt - v0, 0);
    cmp("nc_clear", int'(no_contact), 0);
    poll(8'd40);
    cmp("refill_valid", vcnt - v0, 1);
    cmp("bpm_25", int'(bpm), 25);
    n = 0;
    while (!i2c_send && n < 100) begin @(negedge clk); n++; end
    c0 = cyc;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!timeout_err && n < 100);
    cmp("req_timeout_lat", cyc - c0, TO);
    cmp("req_timeout_send", int'(i2c_send), 0);
    @(negedge clk);
    poll(8'd100);
    cmp("err_sticky", int'(timeout_err), 1);
    cmp("bpm_47", int'(bpm), 47);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    cmp("err_cleared", int'(timeout_err), 0);
    i2c_busy = 1'b1;
    i2c_dout = 8'd200;
    n = 0;
    while (!timeout_err && n < 100) begin @(negedge clk); n++; end
    cmp("rel_timeout", int'(timeout_err), 1);
    i2c_busy = 1'b0;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    poll(8'd120);
    cmp("stuck_discard_bpm", int'(bpm), 72);
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 15)) @(negedge clk);
        enable = 1'b1;
      end
      if (r == 1) begin
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
      end
      if (r == 2) begin
        n = 0;
        while (!i2c_send && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (i2c_send && n < 40) begin @(negedge clk); n++; end
      end
      poll(($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
    end
    n = 0;
    while (!i2c_send && n < 100) begin @(negedge clk); n++; end
    i2c_busy = 1'b1;
    i2c_dout = 8'd33;
    n = 0;
    while (i2c_send && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cmp("rel_rst_send", int'(i2c_send), 0);
    cmp("rel_rst_bpm", int'(bpm), 0);
    cmp("rel_rst_sample", int'(sample), 0);
    cmp("rel_rst_nc", int'(no_contact), 0);
    cmp("rel_rst_err", int'(timeout_err), 0);
    i2c_busy = 1'b0;
    reset = 1'b0;
    c0 = cyc;
    send_latency("post_reset_send_lat", c0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
